// File: rtl/dtu_lane_aligner.sv
// dtu_lane_aligner: serial word aligner for one LiTE-DTU lane (hunt, confirm, lock on synch_pattern)
// Optional build macro DTU_LANE_ALIGNER_ERRCNT_EN adds err_cnt/err_flag for locked-state mismatches.
module dtu_lane_aligner #(
    parameter int WIDTH        = 32,
    parameter int LOCK_MATCHES = 4,
    parameter int MISS_LIMIT   = 3
) (
    input  logic             clock,
    input  logic             rst_b,
    input  logic             ser_in,
    input  logic             sync_mode,
    input  logic [WIDTH-1:0] synch_pattern,
    input  logic             relock,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic [1:0]       state_out
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt,
    output logic             err_flag
`endif
);
    localparam int PW = $clog2(WIDTH);
    typedef enum logic [1:0] {HUNT = 2'b00, CONFIRM = 2'b01, LOCKED = 2'b10} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, word_d;
    logic [PW-1:0]    phase, phase_d;
    logic [3:0]       match_cnt, match_d, miss_cnt, miss_d;
    logic             valid_d, hit, boundary;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
    logic [15:0]      err_d;
    logic             flag_d;
`endif
    assign hit       = shreg == synch_pattern;
    assign boundary  = phase == PW'(WIDTH - 1);
    assign state_out = state;

    // next-state logic: hunt on every bit, then compare only at the locked word boundary
    always_comb begin
        state_d = state;
        phase_d = phase;
        match_d = match_cnt;
        miss_d  = miss_cnt;
        word_d  = word_out;
        valid_d = 1'b0;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
        err_d   = err_cnt;
        flag_d  = 1'b0;
`endif
        if (relock) begin
            state_d = HUNT;
            phase_d = '0;
            match_d = '0;
            miss_d  = '0;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
            err_d   = '0;
`endif
        end else if (state == HUNT) begin
            if (hit) begin
                state_d = (LOCK_MATCHES == 1) ? LOCKED : CONFIRM;
                phase_d = '0;
                match_d = 4'd1;
                miss_d  = '0;
            end
        end else begin
            phase_d = boundary ? '0 : phase + PW'(1);
            if (boundary && state == CONFIRM) begin
                if (hit) begin
                    match_d = match_cnt + 4'd1;
                    if (match_cnt + 4'd1 == 4'(LOCK_MATCHES)) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end
                end else begin
                    state_d = HUNT;
                    match_d = '0;
                end
            end else if (boundary) begin
                word_d  = shreg;
                valid_d = 1'b1;
                if (sync_mode && hit) miss_d = '0;
                else if (sync_mode) begin
                    miss_d = miss_cnt + 4'd1;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
                    if (err_cnt != 16'hFFFF) begin
                        err_d  = err_cnt + 16'd1;
                        flag_d = 1'b1;
                    end
`endif
                    if (miss_cnt + 4'd1 == 4'(MISS_LIMIT)) begin
                        state_d = HUNT;
                        miss_d  = '0;
                    end
                end
            end
        end
    end

    // state and datapath registers; shreg keeps shifting through relock
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            shreg      <= '0;
            state      <= HUNT;
            phase      <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
            err_cnt    <= '0;
            err_flag   <= 1'b0;
`endif
        end else begin
            shreg      <= {shreg[WIDTH-2:0], ser_in};
            state      <= state_d;
            phase      <= phase_d;
            match_cnt  <= match_d;
            miss_cnt   <= miss_d;
            word_out   <= word_d;
            word_valid <= valid_d;
            locked     <= state_d == LOCKED;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
            err_cnt    <= err_d;
            err_flag   <= flag_d;
`endif
        end
    end
endmodule

// File: tb/tb_dtu_lane_aligner.sv
// tb_dtu_lane_aligner: randomized scoreboard bench for dtu_lane_aligner against a time-anchored reference model
module tb_dtu_lane_aligner;
    localparam int WIDTH = 32;
    localparam int LOCK_MATCHES = 4;
    localparam int MISS_LIMIT = 3;

    logic clock = 1'b0;
    logic rst_b = 1'b0;
    logic ser_in = 1'b0;
    logic sync_mode = 1'b1;
    logic relock = 1'b0;
    logic [WIDTH-1:0] synch_pattern = 32'h5A5A_F00F;
    logic [WIDTH-1:0] word_out;
    logic word_valid, locked;
    logic [1:0] state_out;
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
    logic [15:0] err_cnt;
    logic err_flag;
`endif

    dtu_lane_aligner #(.WIDTH(WIDTH), .LOCK_MATCHES(LOCK_MATCHES), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clock(clock), .rst_b(rst_b), .ser_in(ser_in), .sync_mode(sync_mode),
        .synch_pattern(synch_pattern), .relock(relock), .word_out(word_out),
        .word_valid(word_valid), .locked(locked), .state_out(state_out)
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
        , .err_cnt(err_cnt), .err_flag(err_flag)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {logic [WIDTH-1:0] w; int e;} exp_t;
    exp_t q[$];
    int n_vec = 0, n_bad = 0, edge_n = 0;
    int m_state, m_anchor, m_matches, m_misses, m_err;
    bit m_flag;
    logic [WIDTH-1:0] m_win;
    logic [WIDTH-1:0] pat, w;
    int sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_anchor = 0; m_matches = 0; m_misses = 0; m_err = 0; m_flag = 0;
        m_win = '0;
        q.delete();
    endfunction

    // Boundaries are every WIDTH edges after the edge on which HUNT saw the pattern.
    function automatic void model_step(bit b, bit r, bit s, logic [WIDTH-1:0] p);
        bit hit;
        hit = (m_win == p);
        m_flag = 0;
        if (r) begin
            m_state = 0; m_matches = 0; m_misses = 0; m_err = 0;
        end else if (m_state == 0) begin
            if (hit) begin
                m_anchor = edge_n; m_matches = 1; m_misses = 0;
                m_state = (LOCK_MATCHES == 1) ? 2 : 1;
            end
        end else if ((edge_n - m_anchor) % WIDTH == 0) begin
            if (m_state == 1) begin
                if (hit) begin
                    m_matches++;
                    if (m_matches == LOCK_MATCHES) begin m_state = 2; m_misses = 0; end
                end else begin
                    m_state = 0; m_matches = 0;
                end
            end else begin
                q.push_back('{m_win, edge_n});
                if (s && hit) m_misses = 0;
                else if (s) begin
                    m_misses++;
                    if (m_err < 65535) begin m_err++; m_flag = 1; end
                    if (m_misses == MISS_LIMIT) begin m_state = 0; m_misses = 0; end
                end
            end
        end
        m_win = {m_win[WIDTH-2:0], b};
    endfunction

    task automatic tick(input bit b, input bit r, input bit s);
        ser_in = b; relock = r; sync_mode = s;
        @(posedge clock);
        edge_n++;
        if (rst_b) model_step(b, r, s, synch_pattern);
        else model_reset();
        #1;
        relock = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] x, input bit s);
        for (int i = WIDTH - 1; i >= 0; i--) tick(x[i], 1'b0, s);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_word_out", 64'(word_out), 64'd0);
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_state_out", 64'(state_out), 64'd0);
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    endtask

    // Monitor: checks state every cycle and pops the scoreboard on each word_valid.
    always @(negedge clock) begin
        if (rst_b) begin
            chk("state_out", 64'(state_out), 64'(m_state));
            chk("locked", 64'(locked), 64'(m_state == 2));
`ifdef DTU_LANE_ALIGNER_ERRCNT_EN
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            chk("err_flag", 64'(err_flag), 64'(m_flag));
`endif
            while (q.size() != 0 && q[0].e < edge_n) begin
                chk("missing_word_valid", 64'(0), 64'(q[0].w));
                void'(q.pop_front());
            end
            if (word_valid) begin
                if (q.size() == 0) chk("unexpected_word_valid", 64'(word_out), 64'h1_0000_0000);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_out", 64'(word_out), 64'(e.w));
                    chk("word_latency", 64'(edge_n), 64'(e.e));
                end
            end
        end
    end

    initial begin
        pat = 32'h5A5A_F00F;
        model_reset();
        for (int i = 0; i < 5; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        chk_reset_outputs();
        rst_b = 1'b1;
        send_rand(7);
        for (int i = 0; i < 6; i++) send_word(pat, 1'b1);
        chk("lock_acquired", 64'(locked), 64'd1);
        chk("lock_state", 64'(state_out), 64'd2);
        send_word(pat ^ 32'd1, 1'b1);
        send_word(pat ^ 32'd1, 1'b1);
        send_word(pat, 1'b1);
        send_word(pat, 1'b1);
        chk("two_misses_hold", 64'(locked), 64'd1);
        for (int i = 0; i < 3; i++) send_word(pat ^ 32'd1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("three_misses_drop", 64'(state_out), 64'd0);
        for (int i = 0; i < 6; i++) send_word(pat, 1'b1);
        chk("relocked", 64'(locked), 64'd1);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        chk("sync_off_hold", 64'(locked), 64'd1);
        tick(pat[WIDTH-1], 1'b1, 1'b1);
        chk("relock_state", 64'(state_out), 64'd0);
        chk("relock_no_valid", 64'(word_valid), 64'd0);
        for (int i = WIDTH - 2; i >= 0; i--) tick(pat[i], 1'b0, 1'b1);
        send_word(pat, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_word(pat, 1'b1);
        chk("slip_relock", 64'(locked), 64'd1);
        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) send_word(pat, $urandom_range(0, 3) != 0);
            else if (sel == 6) begin
                w = pat ^ (32'd1 << $urandom_range(0, 31));
                send_word(w, 1'($urandom_range(0, 1)));
            end else if (sel == 7) send_word($urandom, 1'($urandom_range(0, 1)));
            else if (sel == 8) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            else tick(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        pat = $urandom;
        synch_pattern = pat;
        for (int i = 0; i < 10; i++) send_word(pat, 1'b1);
        chk("new_pattern_lock", 64'(locked), 64'd1);
        #1;
        rst_b = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        rst_b = 1'b1;
        send_rand(7);
        for (int i = 0; i < 6; i++) send_word(pat, 1'b1);
        chk("post_reset_lock", 64'(locked), 64'd1);
        send_rand(40);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
